// File: rtl/gb_cart_mem_arbiter.sv
// Cartridge memory arbiter: shares one external ROM/save-RAM bus between the
// MBC-translated CPU port and the flash loader with a fixed-latency access FSM.
module gb_cart_mem_arbiter #(
    parameter int unsigned ADDR_W       = 24,
    parameter int unsigned WAIT_CYCLES  = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [7:0]        cpu_wdata_i,
    output logic              cpu_ack_o,
    output logic [7:0]        cpu_rdata_o,

    input  logic              ldr_req_i,
    input  logic              ldr_we_i,
    input  logic [ADDR_W-1:0] ldr_addr_i,
    input  logic [7:0]        ldr_wdata_i,
    output logic              ldr_ack_o,
    output logic [7:0]        ldr_rdata_o,

    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    input  logic [7:0]        mem_rdata_i,
    output logic              mem_ce_o,
    output logic              mem_oe_o,
    output logic              mem_we_o,

    output logic              busy_o,
    output logic              owner_o
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RECOVER
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]  streak_q, streak_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              dir_we_q, dir_we_d;
    logic              owner_q, owner_d;
    logic [7:0]        cpu_rdata_q, cpu_rdata_d;
    logic [7:0]        ldr_rdata_q, ldr_rdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              ldr_ack_q, ldr_ack_d;
    logic              ce_q, ce_d;
    logic              oe_q, oe_d;
    logic              we_q, we_d;
    logic              busy_q, busy_d;

    logic              grant_ldr_c;
    logic              sel_we_c;

    // Loader wins when alone, or when the CPU has starved it for STARVE_LIMIT grants
    assign grant_ldr_c = ldr_req_i && (!cpu_req_i || (streak_q == STARVE_MAX));
    assign sel_we_c    = grant_ldr_c ? ldr_we_i : cpu_we_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            wait_q      <= '0;
            streak_q    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            dir_we_q    <= 1'b0;
            owner_q     <= 1'b0;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            ldr_ack_q   <= 1'b0;
            ce_q        <= 1'b0;
            oe_q        <= 1'b0;
            we_q        <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            streak_q    <= streak_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            dir_we_q    <= dir_we_d;
            owner_q     <= owner_d;
            cpu_rdata_q <= cpu_rdata_d;
            ldr_rdata_q <= ldr_rdata_d;
            cpu_ack_q   <= cpu_ack_d;
            ldr_ack_q   <= ldr_ack_d;
            ce_q        <= ce_d;
            oe_q        <= oe_d;
            we_q        <= we_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        streak_d    = streak_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        dir_we_d    = dir_we_q;
        owner_d     = owner_q;
        cpu_rdata_d = cpu_rdata_q;
        ldr_rdata_d = ldr_rdata_q;
        cpu_ack_d   = 1'b0;
        ldr_ack_d   = 1'b0;
        ce_d        = 1'b0;
        oe_d        = 1'b0;
        we_d        = 1'b0;
        busy_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cpu_req_i || ldr_req_i) begin
                    state_d  = ST_ACCESS;
                    owner_d  = grant_ldr_c;
                    addr_d   = grant_ldr_c ? ldr_addr_i : cpu_addr_i;
                    wdata_d  = grant_ldr_c ? ldr_wdata_i : cpu_wdata_i;
                    dir_we_d = sel_we_c;
                    wait_d   = WAIT_LOAD;
                    ce_d     = 1'b1;
                    oe_d     = !sel_we_c;
                    we_d     = sel_we_c;
                    busy_d   = 1'b1;
                    if (grant_ldr_c || !ldr_req_i) begin
                        streak_d = '0;
                    end else if (streak_q != STARVE_MAX) begin
                        streak_d = streak_q + CNT_W'(1);
                    end
                end
            end

            ST_ACCESS: begin
                busy_d = 1'b1;
                if (wait_q == '0) begin
                    // Last strobe cycle: capture read data, then turn the bus around
                    state_d   = ST_RECOVER;
                    cpu_ack_d = !owner_q;
                    ldr_ack_d = owner_q;
                    if (!dir_we_q) begin
                        if (owner_q) begin
                            ldr_rdata_d = mem_rdata_i;
                        end else begin
                            cpu_rdata_d = mem_rdata_i;
                        end
                    end
                end else begin
                    wait_d = wait_q - CNT_W'(1);
                    ce_d   = 1'b1;
                    oe_d   = !dir_we_q;
                    we_d   = dir_we_q;
                end
            end

            ST_RECOVER: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cpu_ack_o   = cpu_ack_q;
    assign ldr_ack_o   = ldr_ack_q;
    assign cpu_rdata_o = cpu_rdata_q;
    assign ldr_rdata_o = ldr_rdata_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_ce_o    = ce_q;
    assign mem_oe_o    = oe_q;
    assign mem_we_o    = we_q;
    assign busy_o      = busy_q;
    assign owner_o     = owner_q;

endmodule

// File: tb/tb_gb_cart_mem_arbiter.sv
// Bench for gb_cart_mem_arbiter: directed scenarios plus random two-port
// traffic, checked every cycle against a grant-schedule model.
module tb_gb_cart_mem_arbiter;

    localparam int AW = 24;
    localparam int W  = 2;
    localparam int SL = 4;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          cpu_req_i = 1'b0, cpu_we_i = 1'b0;
    logic [AW-1:0] cpu_addr_i = '0;
    logic [7:0]    cpu_wdata_i = '0;
    logic          ldr_req_i = 1'b0, ldr_we_i = 1'b0;
    logic [AW-1:0] ldr_addr_i = '0;
    logic [7:0]    ldr_wdata_i = '0;
    logic          cpu_ack_o, ldr_ack_o;
    logic [7:0]    cpu_rdata_o, ldr_rdata_o;
    logic [AW-1:0] mem_addr_o;
    logic [7:0]    mem_wdata_o;
    logic [7:0]    mem_rdata_i;
    logic          mem_ce_o, mem_oe_o, mem_we_o, busy_o, owner_o;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    int tb_cyc = 0;

    gb_cart_mem_arbiter #(
        .ADDR_W(AW), .WAIT_CYCLES(W), .STARVE_LIMIT(SL)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_wdata_i(cpu_wdata_i), .cpu_ack_o(cpu_ack_o), .cpu_rdata_o(cpu_rdata_o),
        .ldr_req_i(ldr_req_i), .ldr_we_i(ldr_we_i), .ldr_addr_i(ldr_addr_i),
        .ldr_wdata_i(ldr_wdata_i), .ldr_ack_o(ldr_ack_o), .ldr_rdata_o(ldr_rdata_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .mem_ce_o(mem_ce_o), .mem_oe_o(mem_oe_o), .mem_we_o(mem_we_o),
        .busy_o(busy_o), .owner_o(owner_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) tb_cyc <= tb_cyc + 1;

    function automatic logic [7:0] mem_f(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h2D;
    endfunction

    // Slow memory: data is only correct in the final strobe cycle of a read
    int oe_idx = 0;
    always @(posedge clk_i) oe_idx <= mem_oe_o ? oe_idx + 1 : 0;
    assign mem_rdata_i = !mem_oe_o ? 8'hEE :
                         (oe_idx == W - 1) ? mem_f(mem_addr_o) : ~mem_f(mem_addr_o);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at cycle %0d", nm, act, exp, tb_cyc);
        end
    endtask

    // Model: a grant at cycle g owns the bus for cycles g+1..g+W+1
    int            cyc = 0, g = 0, waited = 0;
    bit            has_g = 1'b0, m_who = 1'b0, m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [7:0]    m_wdata = '0, m_rd_cpu = '0, m_rd_ldr = '0;
    logic          m_pick, m_idle;
    int            m_d;

    assign m_pick = ldr_req_i && (!cpu_req_i || waited >= SL);
    assign m_idle = !has_g || (cyc >= g + W + 2);
    assign m_d    = has_g ? (cyc - g) : -1;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            has_g <= 1'b0; m_who <= 1'b0; m_we <= 1'b0; waited <= 0;
            m_addr <= '0; m_wdata <= '0; m_rd_cpu <= '0; m_rd_ldr <= '0;
        end else begin
            cyc <= cyc + 1;
            if (has_g && cyc == g + W && !m_we) begin
                if (m_who) m_rd_ldr <= mem_f(m_addr);
                else       m_rd_cpu <= mem_f(m_addr);
            end
            if (m_idle && (cpu_req_i || ldr_req_i)) begin
                has_g   <= 1'b1;
                g       <= cyc;
                m_who   <= m_pick;
                m_we    <= m_pick ? ldr_we_i : cpu_we_i;
                m_addr  <= m_pick ? ldr_addr_i : cpu_addr_i;
                m_wdata <= m_pick ? ldr_wdata_i : cpu_wdata_i;
                waited  <= (m_pick || !ldr_req_i) ? 0 : ((waited < SL) ? waited + 1 : SL);
            end
        end
    end

    logic e_ce;
    assign e_ce = (m_d >= 1) && (m_d <= W);

    always @(negedge clk_i) begin
        if (chk_en) begin
            chk("ce",        32'(mem_ce_o),    32'(e_ce));
            chk("oe",        32'(mem_oe_o),    32'(e_ce && !m_we));
            chk("we",        32'(mem_we_o),    32'(e_ce && m_we));
            chk("cpu_ack",   32'(cpu_ack_o),   32'(m_d == W + 1 && !m_who));
            chk("ldr_ack",   32'(ldr_ack_o),   32'(m_d == W + 1 && m_who));
            chk("busy",      32'(busy_o),      32'(m_d >= 1 && m_d <= W + 1));
            chk("owner",     32'(owner_o),     32'(m_who));
            chk("mem_addr",  32'(mem_addr_o),  32'(m_addr));
            chk("mem_wdata", 32'(mem_wdata_o), 32'(m_wdata));
            chk("cpu_rdata", 32'(cpu_rdata_o), 32'(m_rd_cpu));
            chk("ldr_rdata", 32'(ldr_rdata_o), 32'(m_rd_ldr));
            chk("ack_overlap", 32'(cpu_ack_o && ldr_ack_o), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_ack(input bit which, output int at);
        int n;
        n = 0;
        @(negedge clk_i);
        while (((which ? ldr_ack_o : cpu_ack_o) == 1'b0) && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        at = tb_cyc;
        if (n >= 20) begin
            total++;
            bad++;
            $display("FAIL ack_timeout port=%0d got=no_ack want=ack", which);
        end
    endtask

    task automatic new_req(input bit which);
        if (which) begin
            ldr_req_i = 1'b1; ldr_we_i = 1'($urandom_range(1));
            ldr_addr_i = 24'($urandom); ldr_wdata_i = 8'($urandom);
        end else begin
            cpu_req_i = 1'b1; cpu_we_i = 1'($urandom_range(1));
            cpu_addr_i = 24'($urandom); cpu_wdata_i = 8'($urandom);
        end
    endtask

    task automatic drive_port(input bit which, input int ncyc);
        bit ack_seen, req_now;
        int r;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk_i);
            ack_seen = which ? ldr_ack_o : cpu_ack_o;
            tick();
            req_now = which ? ldr_req_i : cpu_req_i;
            r = int'($urandom_range(99));
            if (ack_seen) begin
                if (r < 50) begin
                    if (which) ldr_req_i = 1'b0; else cpu_req_i = 1'b0;
                end else begin
                    new_req(which);
                end
            end else if (!req_now) begin
                if (r < 30) new_req(which);
            end else if (r < 5) begin
                if (which) ldr_addr_i = 24'($urandom); else cpu_addr_i = 24'($urandom);
            end else if (r < 8) begin
                if (which) ldr_req_i = 1'b0; else cpu_req_i = 1'b0;
            end
        end
    endtask

    initial begin
        bit            ord [10];
        bit            exp_ord [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        logic [AW-1:0] b2b_addr [4] = '{24'h004150, 24'h000001, 24'hFFFFFF, 24'h8000AA};
        logic [7:0]    b2b_data [4] = '{8'h3C, 8'h2C, 8'hD2, 8'h07};
        int            n_g, at, prev, s;
        bit            prev_ce;

        #2 rst_i = 1'b1;
        chk_en = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_cpu_rdata", 32'(cpu_rdata_o), 32'd0);
        chk("rst_owner",     32'(owner_o),     32'd0);
        chk("rst_ce",        32'(mem_ce_o),    32'd0);
        tick();
        rst_i = 1'b0;

        // CPU read of 0x004150
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 24'h004150;
        @(negedge clk_i);
        chk("rd_c0_ce", 32'(mem_ce_o), 32'd0);
        for (int i = 1; i <= W; i++) begin
            @(negedge clk_i);
            chk("rd_ce",   32'(mem_ce_o),   32'd1);
            chk("rd_oe",   32'(mem_oe_o),   32'd1);
            chk("rd_addr", 32'(mem_addr_o), 32'h004150);
        end
        @(negedge clk_i);
        chk("rd_ack",       32'(cpu_ack_o),   32'd1);
        chk("rd_cpu_rdata", 32'(cpu_rdata_o), 32'h3C);
        chk("rd_ldr_rdata", 32'(ldr_rdata_o), 32'h00);
        tick();
        cpu_req_i = 1'b0;

        // Loader write 0xA5 to 0x0A0010
        tick();
        ldr_req_i = 1'b1; ldr_we_i = 1'b1; ldr_addr_i = 24'h0A0010; ldr_wdata_i = 8'hA5;
        @(negedge clk_i);
        for (int i = 1; i <= W; i++) begin
            @(negedge clk_i);
            chk("wr_we",    32'(mem_we_o),    32'd1);
            chk("wr_oe",    32'(mem_oe_o),    32'd0);
            chk("wr_wdata", 32'(mem_wdata_o), 32'hA5);
        end
        @(negedge clk_i);
        chk("wr_ack",       32'(ldr_ack_o),   32'd1);
        chk("wr_cpu_rdata", 32'(cpu_rdata_o), 32'h3C);
        tick();
        ldr_req_i = 1'b0;

        // Both requesters held high: starvation guard order
        tick();
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 24'h000200;
        ldr_req_i = 1'b1; ldr_we_i = 1'b0; ldr_addr_i = 24'h000300;
        n_g = 0;
        prev_ce = 1'b0;
        for (int i = 0; i < 41; i++) begin
            @(negedge clk_i);
            if (mem_ce_o && !prev_ce && n_g < 10) begin
                ord[n_g] = owner_o;
                n_g++;
            end
            prev_ce = mem_ce_o;
        end
        chk("starve_ngrants", 32'(n_g), 32'd10);
        for (int k = 0; k < 10; k++) chk($sformatf("starve_grant%0d", k), 32'(ord[k]), 32'(exp_ord[k]));
        tick();
        cpu_req_i = 1'b0; ldr_req_i = 1'b0;
        repeat (6) tick();

        // Address change during ACCESS is ignored until the next grant
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 24'h000100;
        @(negedge clk_i);
        tick();
        cpu_addr_i = 24'h123456;
        for (int i = 1; i <= W + 1; i++) begin
            @(negedge clk_i);
            chk("frz_addr", 32'(mem_addr_o), 32'h000100);
        end
        tick();
        @(negedge clk_i);
        chk("frz_idle_addr", 32'(mem_addr_o), 32'h000100);
        @(negedge clk_i);
        chk("new_addr", 32'(mem_addr_o), 32'h123456);
        wait_ack(1'b0, at);
        tick();
        cpu_req_i = 1'b0;
        repeat (2) tick();

        // Reset in the second ACCESS cycle
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 24'h00ABCD;
        tick();
        tick();
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("rstm_ce",   32'(mem_ce_o),  32'd0);
        chk("rstm_oe",   32'(mem_oe_o),  32'd0);
        chk("rstm_busy", 32'(busy_o),    32'd0);
        chk("rstm_ack",  32'(cpu_ack_o), 32'd0);
        tick();
        rst_i = 1'b0;
        s = tb_cyc;
        wait_ack(1'b0, at);
        chk("rstm_latency", 32'(at - s), 32'(W + 1));
        chk("rstm_rdata",   32'(cpu_rdata_o), 32'(mem_f(24'h00ABCD)));
        tick();
        cpu_req_i = 1'b0;

        // Back-to-back CPU reads with req held
        tick();
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = b2b_addr[0];
        s = tb_cyc;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            wait_ack(1'b0, at);
            chk($sformatf("b2b_rdata%0d", i), 32'(cpu_rdata_o), 32'(b2b_data[i]));
            if (i == 0) chk("b2b_first", 32'(at - s), 32'(W + 1));
            else        chk("b2b_period", 32'(at - prev), 32'(W + 2));
            prev = at;
            tick();
            if (i < 3) cpu_addr_i = b2b_addr[i + 1];
            else       cpu_req_i = 1'b0;
        end
        repeat (2) tick();

        // Random traffic on both ports
        fork
            drive_port(1'b0, 3000);
            drive_port(1'b1, 3000);
        join
        cpu_req_i = 1'b0;
        ldr_req_i = 1'b0;
        repeat (8) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gb_cart_mem_arbiter.md
Name: gb_cart_mem_arbiter

Overview:
- Shares the single external cartridge memory (ROM/save-RAM, 24-bit byte address) between two requesters.
  - CPU port: carries addresses already translated by the active MBC.
  - Loader port: ROM image load from flash, and save-RAM backup/restore.
- Runs a fixed-latency access state machine with req/ack handshakes.
- Uses CPU-priority arbitration with a starvation guard for the loader.
- Sits between the MBC output and the memory pins of the watch board.

Parameters:
- ADDR_W, 24: external byte-address width.
- WAIT_CYCLES, 2: cycles mem_ce is held per access. Legal range 1..15.
- STARVE_LIMIT, 4: consecutive CPU grants allowed while loader waits. Legal range 1..15.

Ports:
- clock  in  1  system clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cpu_req  in  1  CPU access request; held until cpu_ack.
- cpu_we  in  1  1=write, 0=read; stable while cpu_req high.
- cpu_addr  in  ADDR_W  translated cartridge address.
- cpu_wdata  in  8  write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  8  last CPU read data; valid from cpu_ack onward.
- ldr_req, ldr_we, ldr_addr[ADDR_W], ldr_wdata[8], ldr_ack, ldr_rdata[8]: identical semantics for the loader.
- mem_addr  out  ADDR_W  external address.
- mem_wdata  out  8  external write data.
- mem_rdata  in  8  external read data.
- mem_ce  out  1  chip enable, active-high.
- mem_oe  out  1  output enable (reads).
- mem_we  out  1  write enable (writes).
- busy  out  1  high in ACCESS or RECOVER.
- owner  out  1  current grant: 0=CPU, 1=loader. Holds last value in IDLE.

Behaviour:
- Reset (async, immediate): state=IDLE.
  - All outputs 0: mem_addr, mem_wdata, ce/oe/we, acks, rdata, busy, owner.
  - Wait counter and starvation counter cleared.
  - Reset mid-access aborts the access: pins drop with rst, and no ack is ever issued for the aborted access.
- FSM states: IDLE, ACCESS, RECOVER.
- IDLE: if any req is high, arbitrate, then on the next edge:
  - register the winner's addr/wdata/we into mem_addr/mem_wdata/the direction flag;
  - set owner;
  - load wait counter = WAIT_CYCLES-1;
  - go to ACCESS.
  - With no req, stay in IDLE with pins deasserted.
- ACCESS:
  - mem_ce=1.
  - Read: mem_oe=1, mem_we=0. Write: mem_we=1, mem_oe=0.
  - Counter decrements each cycle.
  - In the cycle the counter is 0: for a read, sample mem_rdata into the owner's rdata register at that edge; go to RECOVER.
- RECOVER: exactly one cycle.
  - ce/oe/we=0 (bus turnaround).
  - Owner's ack=1; then go to IDLE.
- Latency: req first seen in IDLE cycle 0 gives ce in cycles 1..WAIT_CYCLES and ack in cycle WAIT_CYCLES+1. Minimum spacing between accesses is WAIT_CYCLES+2 cycles.
- Requesters deassert req (or present the next request) on the edge after ack. Since IDLE follows RECOVER, a req held high after ack is a new request.
- Arbitration in IDLE:
  - Only one req high: that requester wins.
  - Both high: CPU wins unless streak==STARVE_LIMIT, then loader wins.
  - streak counter:
    - increments (saturating at STARVE_LIMIT) on a CPU grant while ldr_req is high;
    - clears on any loader grant, or on a CPU grant with ldr_req low.
- rdata registers:
  - Change only on their own read completion.
  - Writes and the other port's reads leave them untouched.
- A req dropped mid-access does not abort it: the access completes and ack still pulses. mem_addr/mem_wdata/direction stay frozen from grant until return to IDLE, regardless of input changes.
- mem_addr and mem_wdata hold their last values in IDLE; only ce/oe/we are deasserted.
- Acks are never high simultaneously, and never outside RECOVER.

Test Plan:
- Reset then CPU read of 0x004150, mem model returns 0x3C (WAIT_CYCLES=2):
  - mem_ce/mem_oe high in cycles 1–2, mem_addr=0x004150;
  - cpu_ack pulses in cycle 3, cpu_rdata=0x3C;
  - ldr_rdata stays 0x00.
- Loader write 0xA5 to 0x0A0010:
  - mem_we high for 2 cycles with mem_wdata=0xA5, mem_oe=0;
  - ldr_ack one cycle; cpu_rdata unchanged.
- Both req continuously high, STARVE_LIMIT=4:
  - grant order CPU,CPU,CPU,CPU,LDR,CPU,CPU,CPU,CPU,LDR;
  - owner matches; acks never overlap.
- cpu_addr changed to 0x123456 during ACCESS: mem_addr stays at the granted address until RECOVER ends; next grant uses the new address.
- rst asserted in the second ACCESS cycle:
  - mem_ce/oe/we fall the same cycle, no ack, state IDLE;
  - after release, a pending req is serviced normally.
- Back-to-back CPU reads with req held: access period is exactly 4 cycles; each ack updates cpu_rdata with that access's mem_rdata.
